maze_move_check: RTL
====================

Name: maze_move_check

Overview:
- Sequential, parametrised successor to the maze solver's combinational return/no-return decision.
- Accepts one candidate cell (row, colomn) per request over a valid/ready handshake.
- Checks the cell against grid bounds, then reads the wall bit from maze memory with a fixed-latency read.
- Returns return_ornot plus a reason code to the solver FSM over a second valid/ready handshake.

Parameters:
- ROWS, 16, grid height; legal rows are 0..ROWS-1.
- COLS, 16, grid width; legal columns are 0..COLS-1.
- COORD_W, 8, width of row/colomn; two's-complement signed.
- MEM_LAT, 1, cycles from the mem_rd cycle to the dout-valid cycle; must be >= 1.
- ADDR_W, $clog2(ROWS*COLS), maze memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  candidate cell presented.
- req_ready  out  1  block can accept a request.
- row  in  COORD_W  signed candidate row.
- colomn  in  COORD_W  signed candidate column.
- mem_rd  out  1  one-cycle read strobe to maze memory.
- mem_addr  out  ADDR_W  read address = row*COLS + colomn.
- dout  in  1  wall bit from memory; 1 = wall.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  solver consumes the response.
- return_ornot  out  1  1 = cell unusable, solver must return.
- reason  out  2  0 = ok, 1 = out of bounds, 2 = wall, 3 = visited.
- clear_visited  in  1  clears the visited map; ignored when the optional feature is compiled out.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, mem_rd=0, mem_addr=0, rsp_valid=0, return_ornot=0, reason=0, wait counter=0.
- rst mid-operation: the outstanding request is abandoned, no response is issued, and any dout arriving later is ignored.
- State machine: IDLE -> CHECK -> (WAIT) -> RESP -> IDLE.
- IDLE:
  - req_ready = 1 only in this state.
  - req_valid & req_ready at cycle T registers row and colomn; next state is CHECK at T+1.
- CHECK (T+1):
  - Out of bounds when row < 0 or row >= ROWS, or colomn < 0 or colomn >= COLS, using signed compares.
  - Out of bounds: go to RESP with return_ornot=1, reason=1; no memory read is issued.
  - In bounds: mem_rd=1 for exactly this cycle, mem_addr = row*COLS + colomn truncated to ADDR_W; load counter with MEM_LAT; go to WAIT.
  - mem_addr holds its value until the next read.
- WAIT:
  - Counter decrements each cycle.
  - dout is sampled in cycle T+1+MEM_LAT, the cycle the counter reaches 0.
  - dout=1: return_ornot=1, reason=2. dout=0: return_ornot=0, reason=0.
  - Next state is RESP.
- Latency from acceptance to rsp_valid:
  - Out of bounds: 2 cycles (rsp_valid at T+2).
  - In bounds: MEM_LAT+2 cycles.
- RESP:
  - rsp_valid=1; return_ornot and reason are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE; rsp_valid deasserts the next cycle.
  - rsp_ready asserted before rsp_valid has no effect.
- Back-to-back requests: minimum spacing is one idle cycle after each response handshake. No pipelining; only one request is in flight.
- Coordinates at the signed extremes (-2^(COORD_W-1), 2^(COORD_W-1)-1) are out of bounds and never wrap into a legal address.

Optional Feature:
- Macro: MAZE_MOVE_CHECK_VISITED_EN.
- Defined:
  - Internal ROWS*COLS-bit visited map, cleared by rst.
  - In CHECK, an in-bounds cell whose visited bit is set goes to RESP with return_ornot=1, reason=3, and no memory read. The bounds check has priority over visited.
  - On entering RESP with reason=0, the cell's visited bit is set.
  - clear_visited=1 clears the whole map next cycle and may be asserted in any state. Clear has priority over a same-cycle mark.
- Undefined:
  - No map; clear_visited is ignored; reason 3 is never produced.

Test Plan:
- Reset then row=3, colomn=5, dout=0, MEM_LAT=1 -> mem_rd at T+1 with mem_addr=53, rsp_valid at T+3, return_ornot=0, reason=0.
- row=-1, colomn=4 -> no mem_rd, rsp_valid at T+2, return_ornot=1, reason=1; repeat with row=2, colomn=16 -> same result.
- row=15, colomn=15, dout=1, MEM_LAT=3 -> mem_addr=255, rsp_valid at T+5, return_ornot=1, reason=2.
- rsp_ready held 0 for 4 cycles -> rsp_valid, return_ornot and reason stable and req_ready=0 throughout; after rsp_ready=1, req_ready=1 next cycle.
- rst asserted during WAIT -> next cycle is IDLE with all outputs at reset values, no rsp_valid, late dout ignored.
- VISITED_EN: (3,5) ok -> reason 0; (3,5) again -> reason 3 with no mem_rd; pulse clear_visited; (3,5) -> reason 0 again.

Source files
------------

// File: rtl/maze_move_check_if.sv
// Request/response and maze-memory signals of the maze move checker.
// slave = checker side, master = solver plus maze memory side.
interface maze_move_check_if #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic signed [COORD_W-1:0] row;
    logic signed [COORD_W-1:0] colomn;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      dout;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      return_ornot;
    logic [1:0]                reason;
    logic                      clear_visited;

    modport master (
        output req_valid, row, colomn, dout, rsp_ready, clear_visited,
        input  req_ready, mem_rd, mem_addr, rsp_valid, return_ornot, reason
    );

    modport slave (
        input  req_valid, row, colomn, dout, rsp_ready, clear_visited,
        output req_ready, mem_rd, mem_addr, rsp_valid, return_ornot, reason
    );
endinterface

// File: rtl/maze_move_check.sv
// Bounds/wall (and, with MAZE_MOVE_CHECK_VISITED_EN, visited) check of one candidate maze cell.
// Latency: rsp_valid 2 cycles after acceptance when rejected without a read, MEM_LAT+2 otherwise.
// Backpressure: one request in flight; req_ready only in IDLE; response held until rsp_ready.
module maze_move_check #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int COORD_W = 8,
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = $clog2(ROWS*COLS)
) (
    input  logic               clk,
    input  logic               rst,
    maze_move_check_if.slave   bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] R_OK      = 2'd0;
    localparam logic [1:0] R_OOB     = 2'd1;
    localparam logic [1:0] R_WALL    = 2'd2;
    localparam logic [1:0] R_VISITED = 2'd3;

    typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              oob_q;
    logic              vis_q;

    int                row_i;
    int                col_i;
    logic              in_bounds;
    logic [ADDR_W-1:0] cand_addr;
    logic              cand_vis;
    logic              wall_sample;

    // Decided at acceptance so that mem_rd/mem_addr are registered and valid throughout CHECK.
    always_comb begin
        row_i     = int'(bus.row);
        col_i     = int'(bus.colomn);
        in_bounds = (row_i >= 0) && (row_i < ROWS) && (col_i >= 0) && (col_i < COLS);
        cand_addr = ADDR_W'(row_i * COLS + col_i);
    end

    assign wall_sample = (state == WAIT) && (cnt == CNT_W'(1));

`ifdef MAZE_MOVE_CHECK_VISITED_EN
    logic [ROWS*COLS-1:0] visited;

    // A clear in the accept cycle takes effect before CHECK, so it must mask the lookup here.
    assign cand_vis = in_bounds && !bus.clear_visited && visited[cand_addr];

    always_ff @(posedge clk) begin
        if (rst || bus.clear_visited) begin
            visited <= '0;
        end else if (wall_sample && !bus.dout) begin
            visited[bus.mem_addr] <= 1'b1;
        end
    end
`else
    logic unused_clear_visited;

    assign cand_vis             = 1'b0;
    assign unused_clear_visited = bus.clear_visited;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.req_ready    <= 1'b1;
            bus.mem_rd       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.return_ornot <= 1'b0;
            bus.reason       <= R_OK;
            cnt              <= '0;
            oob_q            <= 1'b0;
            vis_q            <= 1'b0;
        end else begin
            bus.mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        oob_q         <= !in_bounds;
                        vis_q         <= cand_vis;
                        if (in_bounds && !cand_vis) begin
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= cand_addr;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (oob_q || vis_q) begin
                        bus.rsp_valid    <= 1'b1;
                        bus.return_ornot <= 1'b1;
                        bus.reason       <= oob_q ? R_OOB : R_VISITED;
                        state            <= RESP;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (wall_sample) begin
                        bus.rsp_valid    <= 1'b1;
                        bus.return_ornot <= bus.dout;
                        bus.reason       <= bus.dout ? R_WALL : R_OK;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
